// File: rtl/pu_pkg.sv
// Shared definitions for the pipelined processing unit: term transform,
// tree-depth helper and packed-bus offset arithmetic for the adder tree.
package pu_pkg;

    localparam logic [2:0] APPROX_PREFIX = 3'b100;

    // Ceiling log2, used for the adder-tree depth.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    // Approximate-scale transform: {APPROX_PREFIX, x[xlen-2 -: xlen-3]},
    // computed on a 64-bit carrier; callers cast back down to xlen bits.
    function automatic logic [63:0] pu_approx(input logic [63:0] x, input int unsigned xlen);
        logic [63:0] mask;
        mask = (64'd1 << (xlen - 3)) - 64'd1;
        return (64'(APPROX_PREFIX) << (xlen - 3)) | ((x >> 2) & mask);
    endfunction

    // Bit offset of tree level lvl inside one flat bus holding every level;
    // level j carries (num_in >> j) operands of (xlen + j) bits each.
    function automatic int unsigned tree_off(input int unsigned num_in,
                                             input int unsigned xlen,
                                             input int unsigned lvl);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < lvl; j++) begin
            off += (num_in >> j) * (xlen + j);
        end
        return off;
    endfunction

endpackage

// File: rtl/pu_add_stage.sv
// One registered adder-tree level: K operands of W bits in, K/2 sums of
// W+1 bits out, with the stage valid bit carried alongside.
module pu_add_stage #(
    parameter int unsigned K = 2,
    parameter int unsigned W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_adv,
    input  logic                     i_valid,
    input  logic [K*W-1:0]           i_ops,
    output logic                     o_valid,
    output logic [(K/2)*(W+1)-1:0]   o_sums
);

    localparam int unsigned H = K / 2;

    logic [H*(W+1)-1:0] w_sum;
    logic [H*(W+1)-1:0] r_sum;
    logic               r_valid;

    // Pairwise widening sums of adjacent operands.
    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < H; i++) begin
            w_sum[i*(W+1) +: (W+1)] = {1'b0, i_ops[(2*i)*W +: W]}
                                    + {1'b0, i_ops[(2*i+1)*W +: W]};
        end
    end

    // Stage register: shifts data and valid together only on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_sum   <= w_sum;
        end
    end

    assign o_valid = r_valid;
    assign o_sums  = r_sum;

endmodule

// File: rtl/pu_pipe.sv
// Pipelined processing unit: per-channel pass-through or approximate-scale
// term, registered adder tree, saturating or wrapping XLEN-bit result,
// valid/ready on both sides with a single global stall.
module pu_pipe
    import pu_pkg::*;
#(
    parameter int unsigned XLEN   = 5,
    parameter int unsigned NUM_IN = 4,
    parameter bit          SAT    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*XLEN-1:0]  nums,
    input  logic [NUM_IN-1:0]       wsel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         result,
    output logic                    out_sat
);

    localparam int unsigned LVLS    = clog2(NUM_IN);
    localparam int unsigned SW      = XLEN + LVLS;
    localparam int unsigned OUT_OFF = tree_off(NUM_IN, XLEN, LVLS);
    localparam int unsigned TREE_W  = tree_off(NUM_IN, XLEN, LVLS + 1);

    logic                   w_adv;
    logic [NUM_IN*XLEN-1:0] w_terms;
    logic [NUM_IN*XLEN-1:0] r_terms;
    logic                   r_v0;
    logic [TREE_W-1:0]      w_tree;
    logic [LVLS:0]          w_v;
    logic [SW-1:0]          w_sum;
    logic                   w_over;

    // Whole pipeline moves unless a valid result is being held back.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Per-channel term selection.
    always_comb begin
        w_terms = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            w_terms[i*XLEN +: XLEN] = wsel[i]
                ? XLEN'(pu_approx(64'(nums[i*XLEN +: XLEN]), XLEN))
                : nums[i*XLEN +: XLEN];
        end
    end

    // Stage 1: register the terms; a bubble enters when in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0    <= 1'b0;
            r_terms <= '0;
        end else if (w_adv) begin
            r_v0    <= in_valid;
            r_terms <= w_terms;
        end
    end

    // All tree levels share one flat bus; level 0 is the term register.
    assign w_tree[NUM_IN*XLEN-1:0] = r_terms;
    assign w_v[0]                  = r_v0;

    for (genvar l = 0; l < LVLS; l++) begin : g_lvl
        localparam int unsigned K   = NUM_IN >> l;
        localparam int unsigned W   = XLEN + l;
        localparam int unsigned OFI = tree_off(NUM_IN, XLEN, l);
        localparam int unsigned OFO = tree_off(NUM_IN, XLEN, l + 1);

        pu_add_stage #(
            .K (K),
            .W (W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_adv   (w_adv),
            .i_valid (w_v[l]),
            .i_ops   (w_tree[OFI +: K*W]),
            .o_valid (w_v[l+1]),
            .o_sums  (w_tree[OFO +: (K/2)*(W+1)])
        );
    end

    // The final tree register is the output stage: result and out_sat
    // decode directly from it, so they hold while stalled and clear on reset.
    assign w_sum     = w_tree[OUT_OFF +: SW];
    assign w_over    = |w_sum[SW-1:XLEN];
    assign out_valid = w_v[LVLS];
    assign out_sat   = w_over;

    // Saturate or wrap the registered full-width sum.
    always_comb begin
        result = w_sum[XLEN-1:0];
        if (SAT && w_over) begin
            result = '1;
        end
    end

endmodule

// File: tb/tb_pu_pipe.sv
// Self-checking bench for pu_pipe: saturating and wrapping instances share
// stimulus and are compared against a queue-based transaction model.
module tb_pu_pipe;

    localparam int unsigned XLEN   = 5;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned LAT    = 3;
    localparam int unsigned MAXV   = (1 << XLEN) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready, in_ready_w;
    logic [NUM_IN*XLEN-1:0] nums;
    logic [NUM_IN-1:0]      wsel;
    logic                   out_valid, out_valid_w;
    logic                   out_ready;
    logic [XLEN-1:0]        result, result_w;
    logic                   out_sat, out_sat_w;

    always #5 clk = ~clk;

    pu_pipe #(.XLEN(XLEN), .NUM_IN(NUM_IN), .SAT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .nums(nums), .wsel(wsel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_sat(out_sat)
    );

    pu_pipe #(.XLEN(XLEN), .NUM_IN(NUM_IN), .SAT(1'b0)) u_dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .nums(nums), .wsel(wsel), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .out_sat(out_sat_w)
    );

    typedef struct {
        int unsigned adv_at;
        int unsigned sum;
    } item_t;

    item_t       q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned adv_cnt = 0;
    int unsigned n_out = 0;
    bit          prev_ov = 1'b0;
    bit          prev_rdy = 1'b0;
    logic [XLEN-1:0] prev_res = '0;
    int unsigned last_res, last_sat, last_res_w, last_sat_w;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Spec-level reference: sum of transformed terms.
    function automatic int unsigned model_sum(input logic [NUM_IN*XLEN-1:0] n,
                                              input logic [NUM_IN-1:0] w);
        int unsigned s, v;
        s = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            v = int'(n[i*XLEN +: XLEN]);
            if (w[i]) v = (4 << (XLEN - 3)) + ((v / 4) % (1 << (XLEN - 3)));
            s += v;
        end
        return s;
    endfunction

    // One clock: drive inputs at the falling edge, check outputs, and book
    // the handshakes that the next rising edge will complete.
    task automatic step(input bit iv, input logic [NUM_IN*XLEN-1:0] n,
                        input logic [NUM_IN-1:0] w, input bit ordy, output bit acc);
        bit    exp_ov, adv;
        item_t it;
        @(negedge clk);
        in_valid  = iv;
        nums      = n;
        wsel      = w;
        out_ready = ordy;
        #1;
        exp_ov = (q.size() > 0) && (adv_cnt - q[0].adv_at == LAT);
        adv    = !exp_ov || ordy;
        chk("out_valid", out_valid, exp_ov);
        chk("out_valid_wrap", out_valid_w, exp_ov);
        chk("in_ready", in_ready, adv);
        chk("in_ready_wrap", in_ready_w, adv);
        if (prev_ov && !prev_rdy) chk("hold_result", result, prev_res);
        if (exp_ov && ordy) begin
            it = q.pop_front();
            chk("result", result, (it.sum > MAXV) ? MAXV : it.sum);
            chk("out_sat", out_sat, it.sum > MAXV);
            chk("result_wrap", result_w, it.sum % (MAXV + 1));
            chk("out_sat_wrap", out_sat_w, it.sum > MAXV);
            last_res   = result;
            last_sat   = out_sat;
            last_res_w = result_w;
            last_sat_w = out_sat_w;
            n_out++;
        end
        acc = iv && adv;
        if (acc) q.push_back('{adv_at: adv_cnt, sum: model_sum(n, w)});
        if (adv) adv_cnt++;
        prev_ov  = out_valid;
        prev_rdy = ordy;
        prev_res = result;
    endtask

    task automatic drain(input int unsigned k);
        bit acc;
        repeat (k) step(1'b0, '0, '0, 1'b1, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int unsigned k, c, n0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; nums = '0; wsel = '0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_sat", out_sat, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic sum, exact latency checked by the out_valid model.
        step(1'b1, {5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, 1'b1, acc);
        drain(5);
        chk("basic_result", last_res, 10);
        chk("basic_sat", last_sat, 0);

        // Approximate-scale channel 0.
        step(1'b1, {5'd0, 5'd0, 5'd0, 5'b01100}, 4'b0001, 1'b1, acc);
        drain(5);
        chk("approx_result", last_res, 19);
        chk("approx_sat", last_sat, 0);

        // Saturation vs wrap.
        step(1'b1, {5'd0, 5'd0, 5'd20, 5'd20}, 4'b0000, 1'b1, acc);
        drain(5);
        chk("sat_result", last_res, 31);
        chk("sat_flag", last_sat, 1);
        chk("wrap_result", last_res_w, 8);
        chk("wrap_flag", last_sat_w, 1);

        // Backpressure: six sets, out_ready low from cycle 2 for a while.
        n0 = n_out; k = 1; c = 0;
        while (k <= 6 && c < 100) begin
            step(1'b1, 20'(k), 4'b0000, (c < 2) || (c >= 10), acc);
            if (acc) k++;
            c++;
        end
        drain(8);
        chk("bp_count", n_out - n0, 6);
        chk("bp_last", last_res, 6);

        // Reset with items in flight and a held result at the output.
        repeat (4) step(1'b1, {5'd3, 5'd2, 5'd1, 5'd7}, 4'b0000, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_out_sat", out_sat, 0);
        q.delete();
        prev_ov = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n0 = n_out;
        drain(6);
        chk("post_rst_no_output", n_out - n0, 0);
        step(1'b1, {5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 1'b1, acc);
        drain(5);
        chk("post_rst_result", last_res, 4);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 20'($urandom), 4'($urandom),
                 $urandom_range(0, 3) != 0, acc);
        end
        drain(10);
        chk("rand_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
